// File: rtl/sm_divider.sv
// Sequential sign-magnitude restoring divider: 14-bit magnitude / 7-bit magnitude, one quotient bit per clock.
// Optional build macro SM_DIVIDER_EARLY_EXIT_EN finishes in the load cycle when |dividend| < |divisor|.
module sm_divider (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        start,
  input  logic [14:0] dividend,
  input  logic [7:0]  divisor,
  output logic [13:0] quotient,
  output logic [6:0]  remainder,
  output logic [3:0]  sign,
  output logic        busy,
  output logic        done,
  output logic        dz
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] SIGN_NEG = 4'b1010;
  localparam logic [3:0] SIGN_POS = 4'b1100;

  state_t      state_q;
  logic [13:0] q_q;
  logic [6:0]  d_q;
  logic [7:0]  r_q;
  logic [3:0]  cnt_q;
  logic [13:0] quot_q;
  logic [6:0]  rem_q;
  logic [3:0]  sign_q;
  logic        busy_q;
  logic        done_q;
  logic        dz_q;

  logic [7:0]  t_d;
  logic [7:0]  diff_d;
  logic        ge_d;
  logic [7:0]  r_d;
  logic [13:0] q_d;
  logic        start_ok;

  // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    t_d    = {r_q[6:0], q_q[13]};
    diff_d = t_d - {1'b0, d_q};
    ge_d   = (t_d >= {1'b0, d_q});
    r_d    = ge_d ? diff_d : t_d;
    q_d    = {q_q[12:0], ge_d};
  end

  assign start_ok = start && (state_q != RUN);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      sign_q  <= SIGN_POS;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            q_q    <= dividend[13:0];
            d_q    <= divisor[6:0];
            r_q    <= '0;
            sign_q <= (dividend[14] ^ divisor[7]) ? SIGN_NEG : SIGN_POS;
            dz_q   <= 1'b0;
            if (divisor[6:0] == 7'd0) begin
              state_q <= DONE;
              quot_q  <= 14'h3FFF;
              rem_q   <= '0;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
`ifdef SM_DIVIDER_EARLY_EXIT_EN
            end else if (dividend[13:0] < {7'd0, divisor[6:0]}) begin
              // Quotient is trivially zero; the dividend itself is the remainder.
              state_q <= DONE;
              quot_q  <= '0;
              rem_q   <= dividend[6:0];
              done_q  <= 1'b1;
`endif
            end else begin
              state_q <= RUN;
              cnt_q   <= 4'd13;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          q_q <= q_d;
          r_q <= r_d;
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            quot_q  <= q_d;
            rem_q   <= r_d[6:0];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign sign      = sign_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_sm_divider.sv
// Bench for sm_divider: directed and randomized divides checked against an arithmetic reference.
module tb_sm_divider;

  logic        clock;
  logic        rst_n;
  logic        start;
  logic [14:0] dividend;
  logic [7:0]  divisor;
  logic [13:0] quotient;
  logic [6:0]  remainder;
  logic [3:0]  sign;
  logic        busy;
  logic        done;
  logic        dz;

  int checks   = 0;
  int failures = 0;

  sm_divider dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .sign      (sign),
    .busy      (busy),
    .done      (done),
    .dz        (dz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: edges after the load edge until done is seen.
  function automatic int exp_latency(input logic [14:0] dd, input logic [7:0] dv);
    if (dv[6:0] == 7'd0) return 0;
`ifdef SM_DIVIDER_EARLY_EXIT_EN
    if (int'(dd[13:0]) < int'(dv[6:0])) return 0;
`endif
    return 14;
  endfunction

  function automatic logic [3:0] exp_sign(input logic [14:0] dd, input logic [7:0] dv);
    return (dd[14] != dv[7]) ? 4'b1010 : 4'b1100;
  endfunction

  function automatic logic [13:0] exp_quot(input logic [14:0] dd, input logic [7:0] dv);
    if (dv[6:0] == 7'd0) return 14'h3FFF;
    return 14'(int'(dd[13:0]) / int'(dv[6:0]));
  endfunction

  function automatic logic [6:0] exp_rem(input logic [14:0] dd, input logic [7:0] dv);
    if (dv[6:0] == 7'd0) return 7'd0;
    return 7'(int'(dd[13:0]) % int'(dv[6:0]));
  endfunction

  // Launch one operation and wait (bounded) for done; n = -1 on timeout.
  task automatic run_op(input logic [14:0] dd, input logic [7:0] dv,
                        output int n, output logic busy_k, output logic busy_seen);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    tick();
    start     = 1'b0;
    busy_k    = busy;
    busy_seen = busy;
    n = 0;
    while (done !== 1'b1 && n <= 40) begin
      tick();
      n++;
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    if (done !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    checks++; if (quotient !== 14'd0) begin failures++; $display("FAIL reset_quotient got=%0d exp=0", quotient); end
    checks++; if (remainder !== 7'd0) begin failures++; $display("FAIL reset_remainder got=%0d exp=0", remainder); end
    checks++; if (sign !== 4'b1100) begin failures++; $display("FAIL reset_sign got=%b exp=1100", sign); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (dz !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", dz); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [14:0] dd_t [4] = '{15'h13B3, {1'b1, 14'd1000}, 15'd16383, 15'd5};
    logic [7:0]  dv_t [4] = '{8'h29, 8'd7, {1'b1, 7'd127}, 8'd100};
    int          q_t  [4] = '{123, 142, 129, 0};
    int          r_t  [4] = '{0, 6, 0, 5};
    logic [3:0]  s_t  [4] = '{4'b1100, 4'b1010, 4'b1010, 4'b1100};
    int n; logic bk; logic bs;
    for (int i = 0; i < 4; i++) begin
      run_op(dd_t[i], dv_t[i], n, bk, bs);
      checks++; if (n !== exp_latency(dd_t[i], dv_t[i])) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, n, exp_latency(dd_t[i], dv_t[i])); end
      checks++; if (int'(quotient) !== q_t[i]) begin failures++; $display("FAIL dir%0d_quotient got=%0d exp=%0d", i, quotient, q_t[i]); end
      checks++; if (int'(remainder) !== r_t[i]) begin failures++; $display("FAIL dir%0d_remainder got=%0d exp=%0d", i, remainder, r_t[i]); end
      checks++; if (sign !== s_t[i]) begin failures++; $display("FAIL dir%0d_sign got=%b exp=%b", i, sign, s_t[i]); end
      checks++; if (dz !== 1'b0) begin failures++; $display("FAIL dir%0d_dz got=%b exp=0", i, dz); end
      checks++; if (bk !== (exp_latency(dd_t[i], dv_t[i]) != 0)) begin failures++; $display("FAIL dir%0d_busy_after_load got=%b", i, bk); end
      tick();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL dir%0d_done_pulse_width got=%b exp=0", i, done); end
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] dv_t [2] = '{8'h00, 8'h80};
    int n; logic bk; logic bs;
    for (int i = 0; i < 2; i++) begin
      run_op(15'd300, dv_t[i], n, bk, bs);
      checks++; if (n !== 0) begin failures++; $display("FAIL dz%0d_latency got=%0d exp=0", i, n); end
      checks++; if (dz !== 1'b1) begin failures++; $display("FAIL dz%0d_flag got=%b exp=1", i, dz); end
      checks++; if (quotient !== 14'h3FFF) begin failures++; $display("FAIL dz%0d_quotient got=%h exp=3fff", i, quotient); end
      checks++; if (remainder !== 7'd0) begin failures++; $display("FAIL dz%0d_remainder got=%0d exp=0", i, remainder); end
      checks++; if (bs !== 1'b0) begin failures++; $display("FAIL dz%0d_busy got=%b exp=0", i, bs); end
      checks++; if (sign !== exp_sign(15'd300, dv_t[i])) begin failures++; $display("FAIL dz%0d_sign got=%b exp=%b", i, sign, exp_sign(15'd300, dv_t[i])); end
      tick();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL dz%0d_done_pulse_width got=%b exp=0", i, done); end
    end
  endtask

  task automatic test_abort();
    int n; logic bk; logic bs; int done_seen;
    run_op(15'h13B3, 8'h29, n, bk, bs);
    dividend = {1'b1, 14'd1000};
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (quotient !== 14'd0) begin failures++; $display("FAIL abort_quotient got=%0d exp=0", quotient); end
    checks++; if (remainder !== 7'd0) begin failures++; $display("FAIL abort_remainder got=%0d exp=0", remainder); end
    checks++; if (sign !== 4'b1100) begin failures++; $display("FAIL abort_sign got=%b exp=1100", sign); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (dz !== 1'b0) begin failures++; $display("FAIL abort_dz got=%b exp=0", dz); end
    done_seen = (done === 1'b1) ? 1 : 0;
    repeat (20) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    checks++; if (done_seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_seen); end
  endtask

  task automatic test_start_ignored();
    int n;
    dividend = {1'b1, 14'd1000};
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    repeat (4) begin tick(); n++; end
    dividend = 15'd127;
    divisor  = 8'd1;
    start    = 1'b1;
    tick(); n++;
    start = 1'b0;
    while (done !== 1'b1 && n <= 40) begin tick(); n++; end
    if (done !== 1'b1) n = -1;
    checks++; if (n !== 14) begin failures++; $display("FAIL ignore_latency got=%0d exp=14", n); end
    checks++; if (quotient !== 14'd142) begin failures++; $display("FAIL ignore_quotient got=%0d exp=142", quotient); end
    checks++; if (remainder !== 7'd6) begin failures++; $display("FAIL ignore_remainder got=%0d exp=6", remainder); end
    checks++; if (sign !== 4'b1010) begin failures++; $display("FAIL ignore_sign got=%b exp=1010", sign); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL ignore_done_pulse_width got=%b exp=0", done); end
  endtask

  task automatic test_back_to_back();
    int n; logic bk; logic bs;
    run_op(15'h13B3, 8'h29, n, bk, bs);
    checks++; if (quotient !== 14'd123) begin failures++; $display("FAIL b2b_first_quotient got=%0d exp=123", quotient); end
    run_op(15'd127, 8'd1, n, bk, bs);
    checks++; if (bk !== 1'b1) begin failures++; $display("FAIL b2b_busy_after_load got=%b exp=1", bk); end
    checks++; if (n !== 14) begin failures++; $display("FAIL b2b_latency got=%0d exp=14", n); end
    checks++; if (quotient !== 14'd127) begin failures++; $display("FAIL b2b_quotient got=%0d exp=127", quotient); end
    checks++; if (remainder !== 7'd0) begin failures++; $display("FAIL b2b_remainder got=%0d exp=0", remainder); end
    checks++; if (sign !== 4'b1100) begin failures++; $display("FAIL b2b_sign got=%b exp=1100", sign); end
  endtask

  task automatic test_random();
    logic [14:0] dd; logic [7:0] dv;
    int n; logic bk; logic bs;
    for (int i = 0; i < 40; i++) begin
      dd[14] = 1'($urandom_range(0, 1));
      dd[13:0] = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 200)) : 14'($urandom_range(0, 16383));
      dv[7] = 1'($urandom_range(0, 1));
      dv[6:0] = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      run_op(dd, dv, n, bk, bs);
      checks++; if (n !== exp_latency(dd, dv)) begin failures++; $display("FAIL rnd%0d_latency dd=%h dv=%h got=%0d exp=%0d", i, dd, dv, n, exp_latency(dd, dv)); end
      checks++; if (quotient !== exp_quot(dd, dv)) begin failures++; $display("FAIL rnd%0d_quotient dd=%h dv=%h got=%0d exp=%0d", i, dd, dv, quotient, exp_quot(dd, dv)); end
      checks++; if (remainder !== exp_rem(dd, dv)) begin failures++; $display("FAIL rnd%0d_remainder dd=%h dv=%h got=%0d exp=%0d", i, dd, dv, remainder, exp_rem(dd, dv)); end
      checks++; if (sign !== exp_sign(dd, dv)) begin failures++; $display("FAIL rnd%0d_sign got=%b exp=%b", i, sign, exp_sign(dd, dv)); end
      checks++; if (dz !== (dv[6:0] == 7'd0)) begin failures++; $display("FAIL rnd%0d_dz got=%b exp=%b", i, dz, (dv[6:0] == 7'd0)); end
      checks++; if (bs !== (exp_latency(dd, dv) != 0)) begin failures++; $display("FAIL rnd%0d_busy got=%b", i, bs); end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_abort();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
